// File: rtl/uart_pkg.sv
// Shared UART definitions: FSM state encoding and the baud-period computation
// used by both the transmitter and the receiver.
package uart_pkg;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_START = 3'd1,
        S_DATA  = 3'd2,
        S_STOP  = 3'd3
    } uart_state_e;

    // Clocks per serial bit; clk_fre is in MHz. Widened so large clocks cannot overflow.
    function automatic int calc_cycle(input int clk_fre, input int baud_rate);
        longint num;
        num = longint'(clk_fre) * 64'd1000000;
        return int'(num / longint'(baud_rate));
    endfunction

endpackage

// File: rtl/uart_rx_sync.sv
// Three-flop synchroniser for the asynchronous serial line plus falling-edge detect.
// rx_s_o is the second (metastability-safe) stage; fall_o compares it with the third.
module uart_rx_sync
    import uart_pkg::*;
(
    input  logic clk_i,
    input  logic rst_i,
    input  logic rx_pin_i,
    output logic rx_s_o,
    output logic fall_o
);

    logic meta_q;
    logic sync_q;
    logic dly_q;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            meta_q <= 1'b1;
            sync_q <= 1'b1;
            dly_q  <= 1'b1;
        end else begin
            meta_q <= rx_pin_i;
            sync_q <= meta_q;
            dly_q  <= sync_q;
        end
    end

    assign rx_s_o = sync_q;
    assign fall_o = dly_q & ~sync_q;

endmodule

// File: rtl/uart_rx.sv
// 8N1 UART receiver: mid-bit sampling FSM with a valid/ready byte output,
// one-cycle framing-error and overrun pulses.
module uart_rx
    import uart_pkg::*;
#(
    parameter int CLK_FRE   = 50,
    parameter int BAUD_RATE = 115200
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       rx_pin,
    output logic [7:0] rx_data,
    output logic       rx_data_valid,
    input  logic       rx_data_ready,
    output logic       frame_err,
    output logic       overrun
);

    localparam int          CYCLE     = calc_cycle(CLK_FRE, BAUD_RATE);
    localparam logic [31:0] HALF_LAST = 32'(CYCLE / 2 - 1);
    localparam logic [31:0] BIT_LAST  = 32'(CYCLE - 1);

    logic        rx_s;
    logic        fall;

    uart_state_e state_q;
    logic [31:0] cycle_cnt_q;
    logic [31:0] cycle_cnt_d;
    logic [2:0]  bit_cnt_q;
    logic [7:0]  shift_q;
    logic [7:0]  rx_data_q;
    logic        rx_data_valid_q;
    logic        frame_err_q;
    logic        overrun_q;

    uart_rx_sync u_sync (
        .clk_i    (clk),
        .rst_i    (rst),
        .rx_pin_i (rx_pin),
        .rx_s_o   (rx_s),
        .fall_o   (fall)
    );

    assign cycle_cnt_d = cycle_cnt_q + 32'd1;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q         <= S_IDLE;
            cycle_cnt_q     <= 32'd0;
            bit_cnt_q       <= 3'd0;
            shift_q         <= 8'h00;
            rx_data_q       <= 8'h00;
            rx_data_valid_q <= 1'b0;
            frame_err_q     <= 1'b0;
            overrun_q       <= 1'b0;
        end else begin
            frame_err_q <= 1'b0;
            overrun_q   <= 1'b0;
            // A byte load in S_STOP below overrides this clear in the same cycle.
            if (rx_data_valid_q && rx_data_ready) begin
                rx_data_valid_q <= 1'b0;
            end

            case (state_q)
                S_IDLE: begin
                    cycle_cnt_q <= 32'd0;
                    bit_cnt_q   <= 3'd0;
                    if (fall) begin
                        state_q <= S_START;
                    end
                end

                S_START: begin
                    if (cycle_cnt_q == HALF_LAST) begin
                        cycle_cnt_q <= 32'd0;
                        state_q     <= rx_s ? S_IDLE : S_DATA;
                    end else begin
                        cycle_cnt_q <= cycle_cnt_d;
                    end
                end

                S_DATA: begin
                    if (cycle_cnt_q == BIT_LAST) begin
                        shift_q[bit_cnt_q] <= rx_s;
                        cycle_cnt_q        <= 32'd0;
                        if (bit_cnt_q == 3'd7) begin
                            bit_cnt_q <= 3'd0;
                            state_q   <= S_STOP;
                        end else begin
                            bit_cnt_q <= bit_cnt_q + 3'd1;
                        end
                    end else begin
                        cycle_cnt_q <= cycle_cnt_d;
                    end
                end

                S_STOP: begin
                    if (cycle_cnt_q == BIT_LAST) begin
                        cycle_cnt_q <= 32'd0;
                        state_q     <= S_IDLE;
                        if (rx_s) begin
                            rx_data_q       <= shift_q;
                            rx_data_valid_q <= 1'b1;
                            overrun_q       <= rx_data_valid_q & ~rx_data_ready;
                        end else begin
                            frame_err_q <= 1'b1;
                        end
                    end else begin
                        cycle_cnt_q <= cycle_cnt_d;
                    end
                end

                default: begin
                    state_q     <= S_IDLE;
                    cycle_cnt_q <= 32'd0;
                    bit_cnt_q   <= 3'd0;
                end
            endcase
        end
    end

    assign rx_data       = rx_data_q;
    assign rx_data_valid = rx_data_valid_q;
    assign frame_err     = frame_err_q;
    assign overrun       = overrun_q;

endmodule

// File: tb/tb_uart_rx.sv
// Self-checking bench for uart_rx at 10 clocks per bit: directed scenarios
// followed by random frames checked against a byte-level receiver model.
module tb_uart_rx;

    localparam int CLK_FRE   = 1;
    localparam int BAUD_RATE = 100000;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       rx_pin = 1'b1;
    logic       rx_data_ready = 1'b0;
    logic [7:0] rx_data;
    logic       rx_data_valid;
    logic       frame_err;
    logic       overrun;

    uart_rx #(.CLK_FRE(CLK_FRE), .BAUD_RATE(BAUD_RATE)) dut (
        .clk           (clk),
        .rst           (rst),
        .rx_pin        (rx_pin),
        .rx_data       (rx_data),
        .rx_data_valid (rx_data_valid),
        .rx_data_ready (rx_data_ready),
        .frame_err     (frame_err),
        .overrun       (overrun)
    );

    always #5 clk = ~clk;

    int vectors = 0;
    int miscompares = 0;

    // Output monitor: event counters sampled on the falling clock edge.
    int         cyc = 0;
    int         rise_cnt = 0;
    int         fall_cnt = 0;
    int         vcyc_cnt = 0;
    int         fe_cnt = 0;
    int         ov_cnt = 0;
    int         rise_cyc = 0;
    logic [7:0] last_vdata = 8'h00;
    logic       prev_v = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (rx_data_valid === 1'b1) begin
            vcyc_cnt   <= vcyc_cnt + 1;
            last_vdata <= rx_data;
            if (!prev_v) begin
                rise_cnt <= rise_cnt + 1;
                rise_cyc <= cyc;
            end
        end
        if (prev_v && rx_data_valid === 1'b0) fall_cnt <= fall_cnt + 1;
        if (frame_err === 1'b1) fe_cnt <= fe_cnt + 1;
        if (overrun === 1'b1) ov_cnt <= ov_cnt + 1;
        prev_v <= (rx_data_valid === 1'b1);
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] want);
        vectors++;
        assert (obs === want) else begin
            miscompares++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, want);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Drives one 100-clock frame; optionally pulses ready for one cycle at clock ready_on.
    task automatic send_frame(input logic [7:0] b, input logic stop, input int ready_on);
        int bi;
        for (int i = 0; i < 100; i++) begin
            bi = i / 10;
            if (bi == 0) rx_pin = 1'b0;
            else if (bi <= 8) rx_pin = b[bi-1];
            else rx_pin = stop;
            if (ready_on >= 0) begin
                if (i == ready_on) rx_data_ready = 1'b1;
                else if (i == ready_on + 1) rx_data_ready = 1'b0;
            end
            tick(1);
        end
    endtask

    // Reference model state: whether a received byte is waiting to be taken.
    logic pend;

    initial begin
        int s_rise, s_fe, s_ov, s_vcyc, s_fall, s_cyc;
        logic [7:0] a, b;
        logic stop, r, newpend;
        int gap;

        pend = 1'b0;
        rst = 1'b1;
        tick(3);
        chk("reset_valid", 32'(rx_data_valid), 32'd0);
        chk("reset_data", 32'(rx_data), 32'h00);
        chk("reset_ferr", 32'(frame_err), 32'd0);
        chk("reset_ovr", 32'(overrun), 32'd0);
        rst = 1'b0;
        tick(5);

        // Single byte with ready held high.
        rx_data_ready = 1'b1;
        s_rise = rise_cnt; s_vcyc = vcyc_cnt; s_fe = fe_cnt; s_ov = ov_cnt; s_cyc = cyc;
        send_frame(8'hA5, 1'b1, -1);
        chk("single_rise", 32'(rise_cnt - s_rise), 32'd1);
        chk("single_data", 32'(last_vdata), 32'hA5);
        chk("single_width", 32'(vcyc_cnt - s_vcyc), 32'd1);
        chk("single_latency", 32'(rise_cyc - s_cyc), 32'd98);
        chk("single_flags", 32'(fe_cnt - s_fe + ov_cnt - s_ov), 32'd0);

        // Back-to-back frames while the consumer holds off.
        rx_data_ready = 1'b0;
        s_ov = ov_cnt;
        send_frame(8'h00, 1'b1, -1);
        chk("b2b_first_valid", 32'(rx_data_valid), 32'd1);
        chk("b2b_first_data", 32'(rx_data), 32'h00);
        send_frame(8'hFF, 1'b1, -1);
        chk("b2b_overrun", 32'(ov_cnt - s_ov), 32'd1);
        chk("b2b_second_data", 32'(rx_data), 32'hFF);
        chk("b2b_second_valid", 32'(rx_data_valid), 32'd1);
        rx_data_ready = 1'b1;
        tick(1);
        chk("b2b_taken", 32'(rx_data_valid), 32'd0);

        // Framing error, then a good byte.
        s_rise = rise_cnt; s_fe = fe_cnt;
        send_frame(8'h3C, 1'b0, -1);
        rx_pin = 1'b1;
        tick(20);
        chk("ferr_pulse", 32'(fe_cnt - s_fe), 32'd1);
        chk("ferr_no_valid", 32'(rise_cnt - s_rise), 32'd0);
        chk("ferr_valid_low", 32'(rx_data_valid), 32'd0);
        s_rise = rise_cnt;
        send_frame(8'h12, 1'b1, -1);
        tick(5);
        chk("after_ferr_rise", 32'(rise_cnt - s_rise), 32'd1);
        chk("after_ferr_data", 32'(last_vdata), 32'h12);

        // Short low glitch on an idle line.
        s_rise = rise_cnt; s_fe = fe_cnt; s_ov = ov_cnt;
        rx_pin = 1'b0;
        tick(3);
        rx_pin = 1'b1;
        tick(30);
        chk("glitch_no_valid", 32'(rise_cnt - s_rise), 32'd0);
        chk("glitch_no_flags", 32'(fe_cnt - s_fe + ov_cnt - s_ov), 32'd0);

        // Reset in the middle of 0x81 with an older byte still pending.
        rx_data_ready = 1'b0;
        send_frame(8'h6B, 1'b1, -1);
        chk("pre_rst_pending", 32'(rx_data_valid), 32'd1);
        b = 8'h81;
        for (int i = 0; i < 55; i++) begin
            if (i < 10) rx_pin = 1'b0;
            else rx_pin = b[i/10-1];
            tick(1);
        end
        rst = 1'b1;
        rx_pin = 1'b1;
        #1;
        chk("midrst_valid", 32'(rx_data_valid), 32'd0);
        chk("midrst_data", 32'(rx_data), 32'h00);
        chk("midrst_flags", 32'({frame_err, overrun}), 32'd0);
        tick(2);
        rst = 1'b0;
        rx_data_ready = 1'b1;
        s_rise = rise_cnt; s_fe = fe_cnt; s_ov = ov_cnt;
        tick(20);
        send_frame(8'h55, 1'b1, -1);
        tick(5);
        chk("post_rst_rise", 32'(rise_cnt - s_rise), 32'd1);
        chk("post_rst_data", 32'(last_vdata), 32'h55);
        chk("post_rst_flags", 32'(fe_cnt - s_fe + ov_cnt - s_ov), 32'd0);

        // Ready arrives in the same cycle a second byte loads.
        rx_data_ready = 1'b0;
        a = 8'($urandom);
        b = a ^ 8'($urandom_range(1, 255));
        send_frame(a, 1'b1, -1);
        s_ov = ov_cnt; s_fall = fall_cnt;
        send_frame(b, 1'b1, 97);
        chk("same_cycle_ovr", 32'(ov_cnt - s_ov), 32'd0);
        chk("same_cycle_valid", 32'(rx_data_valid), 32'd1);
        chk("same_cycle_nodrop", 32'(fall_cnt - s_fall), 32'd0);
        chk("same_cycle_data", 32'(rx_data), 32'(b));
        rx_data_ready = 1'b1;
        tick(1);
        chk("same_cycle_taken", 32'(rx_data_valid), 32'd0);
        pend = 1'b0;

        // Random frames against the byte-level model.
        for (int k = 0; k < 12; k++) begin
            b    = 8'($urandom);
            stop = ($urandom_range(0, 3) != 0);
            r    = 1'($urandom_range(0, 1));
            gap  = $urandom_range(0, 12);
            if (!stop && gap < 2) gap = 2;
            rx_data_ready = r;
            s_fe = fe_cnt; s_ov = ov_cnt;
            send_frame(b, stop, -1);
            newpend = stop ? !r : (pend && !r);
            chk("rnd_ferr", 32'(fe_cnt - s_fe), 32'(!stop));
            chk("rnd_ovr", 32'(ov_cnt - s_ov), 32'(stop && pend && !r));
            chk("rnd_valid", 32'(rx_data_valid), 32'(newpend));
            if (stop) begin
                if (r) chk("rnd_taken_data", 32'(last_vdata), 32'(b));
                else chk("rnd_held_data", 32'(rx_data), 32'(b));
            end
            pend = newpend;
            rx_pin = 1'b1;
            if (gap > 0) tick(gap);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
